// File: rtl/reg_wb_pkg.sv
// reg_wb_pkg: shared types and widths for the write-back controller.
//   REG_ADDR_W - register index width (16 registers)
//   REG_DATA_W - register data width
//   wb_entry_t - one pending register write {rd, data}
package reg_wb_pkg;
  localparam int REG_ADDR_W = 4;
  localparam int REG_DATA_W = 16;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [REG_DATA_W-1:0] data;
  } wb_entry_t;
endpackage

// File: rtl/reg_wb_ctrl_if.sv
// reg_wb_ctrl_if: producer handshakes, register-file write port and bypass
// query of the write-back controller.
//   slave  - seen by reg_wb_ctrl (takes results, drives wb_* and q_*)
//   master - seen by the producers / register file / decode side
interface reg_wb_ctrl_if;
  import reg_wb_pkg::*;

  logic                  mem_valid;
  logic [REG_ADDR_W-1:0] mem_rd;
  logic [REG_DATA_W-1:0] mem_data;
  logic                  mem_ready;
  logic                  alu_valid;
  logic [REG_ADDR_W-1:0] alu_rd;
  logic [REG_DATA_W-1:0] alu_data;
  logic                  alu_ready;
  logic                  wb_regwrt;
  logic [REG_ADDR_W-1:0] wb_wr;
  logic [REG_DATA_W-1:0] wb_wd;
  logic [REG_ADDR_W-1:0] q_addr;
  logic                  q_hit;
  logic [REG_DATA_W-1:0] q_data;

  modport slave (
    input  mem_valid, mem_rd, mem_data, alu_valid, alu_rd, alu_data, q_addr,
    output mem_ready, alu_ready, wb_regwrt, wb_wr, wb_wd, q_hit, q_data
  );
  modport master (
    output mem_valid, mem_rd, mem_data, alu_valid, alu_rd, alu_data, q_addr,
    input  mem_ready, alu_ready, wb_regwrt, wb_wr, wb_wd, q_hit, q_data
  );
endinterface

// File: rtl/wb_fifo_2w1r.sv
// wb_fifo_2w1r: circular buffer with two ordered write ports and one read port.
//   clk, rst_n     - clock, async active-low reset (pointers/count cleared)
//   we0_i, wd0_i   - first write (older entry when both ports write)
//   we1_i, wd1_i   - second write (lands after wd0_i, or alone at the tail)
//   re_i           - pop head; ignored when empty
//   head_o         - entry at the read pointer
//   count_o        - occupancy
//   rptr_o, ent_o  - read pointer and raw storage, for the bypass search
module wb_fifo_2w1r
  import reg_wb_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we0_i,
  input  wb_entry_t             wd0_i,
  input  logic                  we1_i,
  input  wb_entry_t             wd1_i,
  input  logic                  re_i,
  output wb_entry_t             head_o,
  output logic [CW-1:0]         count_o,
  output logic [PW-1:0]         rptr_o,
  output wb_entry_t [DEPTH-1:0] ent_o
);
  wb_entry_t [DEPTH-1:0] mem_q;
  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d, wptr1;
  logic [CW-1:0] count_q, count_d;
  logic          re_ok;

  assign re_ok = re_i && (count_q != '0);
  // second port follows the first only when the first actually writes
  assign wptr1 = wptr_q + PW'(we0_i);

  always_comb begin
    wptr_d  = wptr_q + PW'(we0_i) + PW'(we1_i);
    rptr_d  = rptr_q + PW'(re_ok);
    count_d = count_q + CW'(we0_i) + CW'(we1_i) - CW'(re_ok);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // storage needs no reset: only entries inside count are ever consumed
  always_ff @(posedge clk) begin
    if (we0_i) mem_q[wptr_q] <= wd0_i;
    if (we1_i) mem_q[wptr1]  <= wd1_i;
  end

  assign head_o  = mem_q[rptr_q];
  assign count_o = count_q;
  assign rptr_o  = rptr_q;
  assign ent_o   = mem_q;
endmodule

// File: rtl/reg_wb_ctrl.sv
// reg_wb_ctrl: write-back controller. Queues load and ALU results in order
// and retires one register-file write per cycle.
//   clk, rst_n - clock, async active-low reset
//   bus        - reg_wb_ctrl_if.slave: mem/alu valid-ready inputs,
//                registered wb_regwrt/wb_wr/wb_wd, bypass q_addr/q_hit/q_data
// Build option: REG_WB_BYPASS_EN enables the combinational bypass search;
// without it q_hit/q_data are tied to 0.
module reg_wb_ctrl
  import reg_wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  reg_wb_ctrl_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [CW-1:0]         count, free;
  logic [PW-1:0]         rptr;
  wb_entry_t [DEPTH-1:0] ent;
  wb_entry_t             head, mem_e, alu_e;
  logic                  mem_ready, alu_ready, mem_push, alu_push, pop;
  logic                  we0, we1;
  wb_entry_t             wd0;
  logic                  regwrt_q;
  logic [REG_ADDR_W-1:0] wr_q;
  logic [REG_DATA_W-1:0] wd_q;

  // free space from registered count only; same-cycle pop is not credited
  assign free      = DEPTH_C - count;
  assign mem_ready = (free >= CW'(1));
  // mem has priority on the last free slot
  assign alu_ready = (free >= CW'(2)) || ((free >= CW'(1)) && !bus.mem_valid);
  assign mem_push  = bus.mem_valid && mem_ready;
  assign alu_push  = bus.alu_valid && alu_ready;

  assign mem_e = '{rd: bus.mem_rd, data: bus.mem_data};
  assign alu_e = '{rd: bus.alu_rd, data: bus.alu_data};

  // port 0 takes whichever result is older; port 1 only when both push
  assign we0 = mem_push || alu_push;
  assign wd0 = mem_push ? mem_e : alu_e;
  assign we1 = mem_push && alu_push;
  assign pop = (count != '0);

  wb_fifo_2w1r #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .we0_i   (we0),
    .wd0_i   (wd0),
    .we1_i   (we1),
    .wd1_i   (alu_e),
    .re_i    (pop),
    .head_o  (head),
    .count_o (count),
    .rptr_o  (rptr),
    .ent_o   (ent)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regwrt_q <= 1'b0;
      wr_q     <= '0;
      wd_q     <= '0;
    end else begin
      regwrt_q <= pop;
      if (pop) begin
        wr_q <= head.rd;
        wd_q <= head.data;
      end
    end
  end

  assign bus.mem_ready = mem_ready;
  assign bus.alu_ready = alu_ready;
  assign bus.wb_regwrt = regwrt_q;
  assign bus.wb_wr     = wr_q;
  assign bus.wb_wd     = wd_q;

`ifdef REG_WB_BYPASS_EN
  logic                  hit;
  logic [REG_DATA_W-1:0] hdata;
  logic [PW-1:0]         idx;

  // walk oldest to newest so the last match (newest) wins;
  // the output register is older than anything still queued
  always_comb begin
    hit   = 1'b0;
    hdata = '0;
    idx   = '0;
    if (regwrt_q && (wr_q == bus.q_addr)) begin
      hit   = 1'b1;
      hdata = wd_q;
    end
    for (int i = 0; i < DEPTH; i++) begin
      idx = rptr + PW'(i);
      if ((CW'(i) < count) && (ent[idx].rd == bus.q_addr)) begin
        hit   = 1'b1;
        hdata = ent[idx].data;
      end
    end
  end

  assign bus.q_hit  = hit;
  assign bus.q_data = hdata;
`else
  logic unused_bypass;
  assign unused_bypass = ^{bus.q_addr, ent, rptr};
  assign bus.q_hit     = 1'b0;
  assign bus.q_data    = '0;
`endif
endmodule

// File: tb/tb_reg_wb_ctrl.sv
module tb_reg_wb_ctrl;
  import reg_wb_pkg::*;

  localparam int DEPTH = 4;
`ifdef REG_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  reg_wb_ctrl_if bus ();
  reg_wb_ctrl #(.DEPTH(DEPTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  int n_acc   = 0;
  int n_ret   = 0;

  // reference model: pending writes in acceptance order + last retired write
  wb_entry_t   mq[$];
  logic        exp_we = 1'b0;
  logic [3:0]  exp_wr = '0;
  logic [15:0] exp_wd = '0;

  // register file fed by the DUT write port, captured on the falling edge
  logic [15:0] rf [16];
  always @(negedge clk) if (bus.wb_regwrt === 1'b1) rf[bus.wb_wr] <= bus.wb_wd;

  function automatic logic exp_mem_ready();
    return mq.size() < DEPTH;
  endfunction

  function automatic logic exp_alu_ready(input logic mv);
    int f;
    f = DEPTH - mq.size();
    return (f >= 2) || (f >= 1 && !mv);
  endfunction

  task automatic exp_bypass(input logic [3:0] a, output logic h, output logic [15:0] d);
    h = 1'b0;
    d = '0;
    if (exp_we && exp_wr == a) begin h = 1'b1; d = exp_wd; end
    foreach (mq[i]) if (mq[i].rd == a) begin h = 1'b1; d = mq[i].data; end
    if (!BYP) begin h = 1'b0; d = '0; end
  endtask

  task automatic drive(input logic mv, input logic [3:0] mrd, input logic [15:0] md,
                       input logic av, input logic [3:0] ard, input logic [15:0] ad,
                       input logic [3:0] qa);
    @(negedge clk);
    bus.mem_valid = mv; bus.mem_rd = mrd; bus.mem_data = md;
    bus.alu_valid = av; bus.alu_rd = ard; bus.alu_data = ad;
    bus.q_addr    = qa;
    #1;
  endtask

  task automatic drive_idle(input logic [3:0] qa);
    drive(1'b0, 4'h0, 16'h0, 1'b0, 4'h0, 16'h0, qa);
  endtask

  task automatic drive_rand(input logic mv, input logic av);
    drive(mv, 4'($urandom_range(0, 15)), 16'($urandom), av, 4'($urandom_range(0, 15)),
          16'($urandom), 4'($urandom_range(0, 15)));
  endtask

  // advance one rising edge and update the model: retire head, then enqueue
  task automatic tick();
    int sz;
    logic mr, ar;
    wb_entry_t e;
    @(posedge clk);
    sz = mq.size();
    mr = exp_mem_ready();
    ar = exp_alu_ready(bus.mem_valid);
    if (sz != 0) begin
      e = mq.pop_front();
      exp_we = 1'b1; exp_wr = e.rd; exp_wd = e.data;
    end else begin
      exp_we = 1'b0;
    end
    if (bus.mem_valid && mr) begin mq.push_back('{rd: bus.mem_rd, data: bus.mem_data}); n_acc++; end
    if (bus.alu_valid && ar) begin mq.push_back('{rd: bus.alu_rd, data: bus.alu_data}); n_acc++; end
    #1;
    if (bus.wb_regwrt === 1'b1) n_ret++;
  endtask

  task automatic test_reset();
    bus.mem_valid = 1'b0; bus.mem_rd = '0; bus.mem_data = '0;
    bus.alu_valid = 1'b0; bus.alu_rd = '0; bus.alu_data = '0;
    bus.q_addr = 4'd0;
    #3;
    n_total++;
    if ({bus.wb_regwrt, bus.wb_wr, bus.wb_wd} !== 21'd0)
      $display("FAIL reset_wb: got %b/%h/%h want 0/0/0", bus.wb_regwrt, bus.wb_wr, bus.wb_wd);
    else n_pass++;
    n_total++;
    if ({bus.mem_ready, bus.alu_ready} !== 2'b11)
      $display("FAIL reset_ready: got %b%b want 11", bus.mem_ready, bus.alu_ready);
    else n_pass++;
    n_total++;
    if ({bus.q_hit, bus.q_data} !== 17'd0)
      $display("FAIL reset_bypass: got %b/%h want 0/0000", bus.q_hit, bus.q_data);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    drive(1'b1, 4'd3, 16'h00A5, 1'b0, 4'd0, 16'h0, 4'd0);
    n_total++;
    if ({bus.mem_ready, bus.alu_ready} !== 2'b11)
      $display("FAIL single_ready: got %b%b want 11", bus.mem_ready, bus.alu_ready);
    else n_pass++;
    tick();
    n_total++;
    if (bus.wb_regwrt !== 1'b0) $display("FAIL single_lat0: got %b want 0", bus.wb_regwrt);
    else n_pass++;
    drive_idle(4'd0);
    tick();
    n_total++;
    if ({bus.wb_regwrt, bus.wb_wr, bus.wb_wd} !== {1'b1, 4'd3, 16'h00A5})
      $display("FAIL single_wb: got %b/%h/%h want 1/3/00a5", bus.wb_regwrt, bus.wb_wr, bus.wb_wd);
    else n_pass++;
    drive_idle(4'd0);
    tick();
    n_total++;
    if (bus.wb_regwrt !== 1'b0) $display("FAIL single_once: got %b want 0", bus.wb_regwrt);
    else n_pass++;
  endtask

  task automatic test_same_rd();
    drive(1'b1, 4'd2, 16'h1111, 1'b1, 4'd2, 16'h2222, 4'd0);
    tick();
    drive_idle(4'd0);
    tick();
    n_total++;
    if ({bus.wb_regwrt, bus.wb_wr, bus.wb_wd} !== {1'b1, 4'd2, 16'h1111})
      $display("FAIL same_rd_first: got %b/%h/%h want 1/2/1111", bus.wb_regwrt, bus.wb_wr, bus.wb_wd);
    else n_pass++;
    drive_idle(4'd0);
    tick();
    n_total++;
    if ({bus.wb_regwrt, bus.wb_wr, bus.wb_wd} !== {1'b1, 4'd2, 16'h2222})
      $display("FAIL same_rd_second: got %b/%h/%h want 1/2/2222", bus.wb_regwrt, bus.wb_wr, bus.wb_wd);
    else n_pass++;
    drive_idle(4'd0);
    tick();
    @(negedge clk);
    #1;
    n_total++;
    if (rf[2] !== 16'h2222) $display("FAIL same_rd_rf: got r2=%h want 2222", rf[2]);
    else n_pass++;
  endtask

  // both ports offer every cycle (stream) or randomly; model checks readies,
  // retirement order and bypass every cycle
  task automatic test_traffic(input string name, input int cycles, input bit always_on);
    logic h;
    logic [15:0] d;
    int acc0, ret0;
    acc0 = n_acc;
    ret0 = n_ret;
    for (int c = 0; c < cycles + 12; c++) begin
      if (c < cycles) begin
        if (always_on) drive_rand(1'b1, 1'b1);
        else drive_rand(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end else begin
        if (mq.size() == 0 && !exp_we) break;
        drive_idle(4'($urandom_range(0, 15)));
      end
      n_total++;
      if ({bus.mem_ready, bus.alu_ready} !== {exp_mem_ready(), exp_alu_ready(bus.mem_valid)})
        $display("FAIL %s_ready c%0d: got %b%b want %b%b", name, c, bus.mem_ready, bus.alu_ready,
                 exp_mem_ready(), exp_alu_ready(bus.mem_valid));
      else n_pass++;
      tick();
      n_total++;
      if ({bus.wb_regwrt, bus.wb_wr, bus.wb_wd} !== {exp_we, exp_wr, exp_wd})
        $display("FAIL %s_wb c%0d: got %b/%h/%h want %b/%h/%h", name, c, bus.wb_regwrt,
                 bus.wb_wr, bus.wb_wd, exp_we, exp_wr, exp_wd);
      else n_pass++;
      exp_bypass(bus.q_addr, h, d);
      n_total++;
      if ({bus.q_hit, bus.q_data} !== {h, d})
        $display("FAIL %s_bypass c%0d q=%0d: got %b/%h want %b/%h", name, c, bus.q_addr,
                 bus.q_hit, bus.q_data, h, d);
      else n_pass++;
    end
    n_total++;
    if ((n_ret - ret0) !== (n_acc - acc0) || (n_acc - acc0) < 20)
      $display("FAIL %s_count: got %0d writes want %0d accepted (>=20)", name, n_ret - ret0, n_acc - acc0);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    for (int c = 0; c < 2; c++) begin
      drive_rand(1'b1, 1'b1);
      tick();
    end
    n_total++;
    if ({bus.wb_regwrt, mq.size()} !== {1'b1, 32'd3})
      $display("FAIL rstmid_pre: got regwrt=%b queued=%0d want 1/3", bus.wb_regwrt, mq.size());
    else n_pass++;
    drive_idle(4'd0);
    #2 rst_n = 1'b0;
    mq.delete();
    exp_we = 1'b0; exp_wr = '0; exp_wd = '0;
    #1;
    n_total++;
    if ({bus.wb_regwrt, bus.wb_wr, bus.wb_wd} !== 21'd0)
      $display("FAIL rstmid_wb: got %b/%h/%h want 0/0/0", bus.wb_regwrt, bus.wb_wr, bus.wb_wd);
    else n_pass++;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      drive_idle(4'd0);
      n_total++;
      if ({bus.mem_ready, bus.alu_ready} !== 2'b11)
        $display("FAIL rstmid_ready c%0d: got %b%b want 11", c, bus.mem_ready, bus.alu_ready);
      else n_pass++;
      tick();
      n_total++;
      if (bus.wb_regwrt !== 1'b0) $display("FAIL rstmid_nowrite c%0d: got %b want 0", c, bus.wb_regwrt);
      else n_pass++;
    end
  endtask

  task automatic test_bypass();
    drive(1'b1, 4'd15, 16'h0001, 1'b1, 4'd15, 16'h0002, 4'd15);
    tick();
    n_total++;
    if ({bus.q_hit, bus.q_data} !== (BYP ? {1'b1, 16'h0002} : 17'd0))
      $display("FAIL bypass_r15: got %b/%h want %b/%h", bus.q_hit, bus.q_data, BYP, BYP ? 16'h0002 : 16'h0);
    else n_pass++;
    bus.q_addr = 4'd4;
    #1;
    n_total++;
    if ({bus.q_hit, bus.q_data} !== 17'd0)
      $display("FAIL bypass_r4: got %b/%h want 0/0000", bus.q_hit, bus.q_data);
    else n_pass++;
    drive_idle(4'd15);
    tick();
    n_total++;
    if ({bus.wb_regwrt, bus.wb_wr, bus.wb_wd, bus.q_hit, bus.q_data} !==
        {1'b1, 4'd15, 16'h0001, BYP, (BYP ? 16'h0002 : 16'h0)})
      $display("FAIL bypass_ret1: got %b/%h/%h hit %b/%h want 1/f/0001 hit %b", bus.wb_regwrt,
               bus.wb_wr, bus.wb_wd, bus.q_hit, bus.q_data, BYP);
    else n_pass++;
    drive_idle(4'd15);
    tick();
    n_total++;
    if ({bus.wb_regwrt, bus.wb_wr, bus.wb_wd} !== {1'b1, 4'd15, 16'h0002})
      $display("FAIL bypass_ret2: got %b/%h/%h want 1/f/0002", bus.wb_regwrt, bus.wb_wr, bus.wb_wd);
    else n_pass++;
    drive_idle(4'd0);
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_same_rd();
    test_traffic("stream", 24, 1'b1);
    test_traffic("random", 150, 1'b0);
    test_reset_mid();
    test_bypass();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, %0d/%0d checks so far", n_pass, n_total);
    $fatal(1);
  end
endmodule
